// File: rtl/rx_word_fifo_if.sv
// Word-stream interface between the PHY reception stage, the receive FIFO and
// the link-layer consumer. master = producer/consumer side, slave = FIFO side.
interface rx_word_fifo_if #(
    parameter int ADDR_W = 3
) ();
    logic [31:0]     data_in;
    logic            valid_in;
    logic            pop;
    logic [31:0]     data_out;
    logic            valid_out;
    logic            fifo_full;
    logic            fifo_empty;
    logic            almost_full;
    logic            almost_empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            underflow;

    modport master (
        output data_in, valid_in, pop,
        input  data_out, valid_out, fifo_full, fifo_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  data_in, valid_in, pop,
        output data_out, valid_out, fifo_full, fifo_empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/rx_word_fifo.sv
// Receive-side elastic buffer: DEPTH x 32-bit circular FIFO with registered
// head output, occupancy watermarks and sticky overflow/underflow errors.
module rx_word_fifo #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic            clk_2f,
    input  logic            reset,
    rx_word_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic [31:0]       data_out_reg;
    logic              valid_out_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic full;
    logic empty;
    logic pop_ok;
    logic push_ok;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign pop_ok  = bus.pop && !empty;
    assign push_ok = bus.valid_in && (!full || pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk_2f) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= 32'h0;
            valid_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                data_out_reg  <= mem[rd_ptr_reg];
                valid_out_reg <= 1'b1;
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
            end else begin
                valid_out_reg <= 1'b0;
            end
            if (bus.valid_in && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            if (bus.pop && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign bus.data_out     = data_out_reg;
    assign bus.valid_out    = valid_out_reg;
    assign bus.count        = count_reg;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = (count_reg >= AF_CNT);
    assign bus.almost_empty = (count_reg <= AE_CNT);
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_rx_word_fifo.sv
// Directed bench for rx_word_fifo: a queue model of the FIFO supplies every
// expected word and flag; each cycle's outputs are compared after the edge.
module tb_rx_word_fifo;
    logic clk_2f;
    logic reset;

    rx_word_fifo_if #(.ADDR_W(3)) bus ();

    rx_word_fifo #(
        .DEPTH(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_data;
    logic        exp_valid;
    logic        model_ov;
    logic        model_un;
    logic        saw_beef;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        logic [31:0] w;
        sz = model_q.size();
        check({tag, ".valid_out"}, 32'(bus.valid_out), 32'(exp_valid));
        if (exp_valid && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            last_data = w;
            if (bus.data_out === 32'hDEADBEEF) saw_beef = 1'b1;
        end
        check({tag, ".data_out"},     bus.data_out,             last_data);
        check({tag, ".count"},        32'(bus.count),           32'(sz));
        check({tag, ".fifo_full"},    32'(bus.fifo_full),       32'(sz == 8));
        check({tag, ".fifo_empty"},   32'(bus.fifo_empty),      32'(sz == 0));
        check({tag, ".almost_full"},  32'(bus.almost_full),     32'(sz >= 6));
        check({tag, ".almost_empty"}, 32'(bus.almost_empty),    32'(sz <= 2));
        check({tag, ".overflow"},     32'(bus.overflow),        32'(model_ov));
        check({tag, ".underflow"},    32'(bus.underflow),       32'(model_un));
    endtask

    // One clock: drive inputs, predict the edge, then compare 1 time unit later.
    task automatic step(input string tag, input logic vin, input logic [31:0] din, input logic p);
        bit pop_ok;
        bit push_ok;
        bus.valid_in = vin;
        bus.data_in  = din;
        bus.pop      = p;
        pop_ok  = p && (model_q.size() > 0);
        push_ok = vin && ((model_q.size() < 8) || pop_ok);
        if (vin && !push_ok) model_ov = 1'b1;
        if (p && model_q.size() == 0) model_un = 1'b1;
        exp_valid = pop_ok;
        if (pop_ok) exp_q.push_back(model_q.pop_front());
        if (push_ok) model_q.push_back(din);
        @(posedge clk_2f);
        #1;
        bus.valid_in = 1'b0;
        bus.pop      = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag, input int cycles);
        bus.valid_in = 1'b1;
        bus.data_in  = 32'h55AA55AA;
        bus.pop      = 1'b0;
        reset        = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_data = 32'h0;
        exp_valid = 1'b0;
        model_ov  = 1'b0;
        model_un  = 1'b0;
        #1;
        check_outputs({tag, ".async"});
        repeat (cycles) @(posedge clk_2f);
        #1;
        check_outputs({tag, ".held"});
        bus.valid_in = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        bus.data_in  = 32'h0;
        bus.valid_in = 1'b0;
        bus.pop      = 1'b0;
        reset        = 1'b1;
        last_data    = 32'h0;
        exp_valid    = 1'b0;
        model_ov     = 1'b0;
        model_un     = 1'b0;
        saw_beef     = 1'b0;
        #2;

        do_reset("reset", 3);

        for (int i = 0; i < 8; i++) step("fill", 1'b1, 32'hA0000000 + 32'(i), 1'b0);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 8; i++) step("ovf_fill", 1'b1, 32'hA1000000 + 32'(i), 1'b0);
        step("ovf_push", 1'b1, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 8; i++) step("ovf_drain", 1'b0, 32'h0, 1'b1);
        check("ovf_no_beef", 32'(saw_beef), 32'h0);

        do_reset("reset2", 1);
        step("unf_pop", 1'b0, 32'h0, 1'b1);
        step("empty_pushpop", 1'b1, 32'h12345678, 1'b1);
        step("unf_pop2", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 5; i++) step("wrap_push", 1'b1, 32'hE0 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_pop", 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) step("wrap_pushB", 1'b1, 32'hB0 + 32'(i), 1'b0);
        for (int i = 0; i < 6; i++) step("wrap_popB", 1'b0, 32'h0, 1'b1);

        do_reset("reset3", 1);
        for (int i = 0; i < 8; i++) step("full_fill", 1'b1, 32'hC0000000 + 32'(i), 1'b0);
        step("full_pushpop", 1'b1, 32'hC0FFEE00, 1'b1);
        for (int i = 0; i < 8; i++) step("full_drain", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 5; i++) step("mid_push", 1'b1, 32'hD0 + 32'(i), 1'b0);
        @(negedge clk_2f);
        do_reset("mid_reset", 1);
        step("post_push", 1'b1, 32'h0BADF00D, 1'b0);
        step("post_pop", 1'b0, 32'h0, 1'b1);
        step("post_idle", 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rx_word_fifo.md
Name: rx_word_fifo

Overview:
- Receive-side elastic buffer directly downstream of the PHY reception stage.
- Accepts the 32-bit unstriped words plus their valid strobe, stores them in a DEPTH-entry circular buffer, and releases them to the link-layer consumer on a pop request.
- Reports occupancy, almost-full/almost-empty watermarks, and sticky overflow/underflow errors so the consumer can throttle reads or flag lost data.
- Runs on the unstriping output clock clk_2f.

Parameters:
DEPTH, 8, number of 32-bit entries; power of two, minimum 4
ADDR_W, 3, log2(DEPTH)
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk_2f  input  1  sole clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  32  word from the PHY reception stage
valid_in  input  1  push request; data_in is written when accepted
pop  input  1  consumer read request
data_out  output  32  registered head word
valid_out  output  1  one-cycle strobe qualifying data_out
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push dropped while full
underflow  output  1  sticky: pop ignored while empty

Behaviour:
- Reset is asynchronous, active-low, and effective immediately regardless of clock.
  - Values in reset: wr_ptr=0, rd_ptr=0, count=0, data_out=32'h0, valid_out=0, overflow=0, underflow=0.
  - Storage contents are not reset.
  - Flags in reset: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
- Reset asserted mid-operation discards all stored words. The first push after reset release is written to entry 0.
- Accepted push: valid_in && (!fifo_full || accepted pop).
  - Writes mem[wr_ptr] = data_in.
  - wr_ptr increments modulo DEPTH (natural wrap from DEPTH-1 to 0).
- Accepted pop: pop && !fifo_empty.
  - On that edge, data_out <= mem[rd_ptr] and valid_out <= 1; rd_ptr increments modulo DEPTH.
  - Latency: pop sampled at edge k produces data at edge k, visible in cycle k+1.
  - valid_out is high exactly one cycle per accepted pop. Otherwise valid_out <= 0 and data_out holds its last value.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push+pop:
  - When full: both accepted; count stays DEPTH; no overflow.
  - When empty: push accepted, pop rejected (no bypass); count becomes 1; underflow sets; valid_out stays 0.
  - When partially filled: both accepted; count unchanged.
- Overflow: valid_in while full without an accepted pop drops the word, sets overflow, and leaves pointers unchanged. overflow clears only on reset.
- Underflow: pop while empty sets underflow; pointers and data_out are unchanged. underflow clears only on reset.
- Flags are decoded combinationally from registered count only; there is no combinational path from inputs to outputs.
- Ordering is strict FIFO. Words are never duplicated or reordered across pointer wrap-around.

Test Plan:
- Reset: hold reset=0 for 3 cycles with valid_in=1 -> count=0, fifo_empty=1, almost_empty=1, valid_out=0, data_out=0, overflow=0.
- Fill then drain: push 32'hA0000000..32'hA0000007 (8 words) -> count=8, fifo_full=1, almost_full asserted at count 6. Pop 8 times -> valid_out pulses with words in order, one cycle after each pop; final fifo_empty=1.
- Overflow: FIFO full, push 32'hDEADBEEF -> overflow=1, count stays 8. Draining yields no 32'hDEADBEEF; overflow stays 1 until reset.
- Underflow and empty push+pop: on empty FIFO, pop=1 alone -> underflow=1, valid_out=0. Then push 32'h12345678 with pop=1 -> count=1, valid_out=0. Next pop -> data_out=32'h12345678, valid_out=1.
- Wrap-around: push 5, pop 5, push 6 words 32'hB0..32'hB5, pop 6 -> outputs exactly B0..B5 in order; count returns to 0 across the pointer wrap.
- Full simultaneous push+pop: with count=8, push 32'hC0FFEE00 and pop same cycle -> count=8, overflow=0, head word output. 32'hC0FFEE00 is emerged as the 8th subsequent pop.
- Reset mid-operation: with count=5, assert reset for 1 cycle -> count=0, fifo_empty=1, valid_out=0 immediately. The next push/pop returns the newly pushed word.
